sar_sequencer: RTL and testbench

//  Conversion controller driving the SAR bit-logic block: generates seq_init/seq_update strobes,

---
 rtl/sar_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sar_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: drives init/comp/update strobes, captures decisions MSB-first,
// returns the word on a valid/ready port. Optional macro SAR_OVERRUN_EN adds a sticky overrun flag.
module sar_sequencer #(
   parameter int Nbits    = 16,
   parameter int COMP_DLY = 2,
   parameter int PULSE_W  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic             comp,
   input  logic             result_ready,
   output logic             seq_init,
   output logic             seq_update,
   output logic             seq_comp,
   output logic             sar_mode,
   output logic             busy,
   output logic [Nbits-1:0] result,
   output logic             result_valid
`ifdef SAR_OVERRUN_EN
   ,
   output logic             overrun
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_COMP, S_UPD, S_GAP, S_DONE} state_e;

   localparam int KW   = (Nbits > 1) ? $clog2(Nbits) : 1;
   localparam int CMAX = (COMP_DLY > PULSE_W + 1) ? COMP_DLY : PULSE_W + 1;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] INIT_LAST = CW'(PULSE_W);
   localparam logic [CW-1:0] COMP_LAST = CW'(COMP_DLY - 1);
   localparam logic [CW-1:0] UPD_LAST  = CW'(PULSE_W - 1);
   localparam logic [KW-1:0] K_TOP     = KW'(Nbits - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KW-1:0]    k_q, k_d;
   logic [Nbits-1:0] sh_q, sh_d;
   logic             mode_q, mode_d;
   logic             init_q, init_d, upd_q, upd_d, cmp_q, cmp_d, busy_q, busy_d;
   logic [Nbits-1:0] res_q, res_d;
   logic             vld_q, vld_d;
`ifdef SAR_OVERRUN_EN
   logic             ovr_q, ovr_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         k_q     <= K_TOP;
         sh_q    <= '0;
         mode_q  <= 1'b0;
         init_q  <= 1'b0;
         upd_q   <= 1'b0;
         cmp_q   <= 1'b0;
         busy_q  <= 1'b0;
         res_q   <= '0;
         vld_q   <= 1'b0;
`ifdef SAR_OVERRUN_EN
         ovr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         sh_q    <= sh_d;
         mode_q  <= mode_d;
         init_q  <= init_d;
         upd_q   <= upd_d;
         cmp_q   <= cmp_d;
         busy_q  <= busy_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
`ifdef SAR_OVERRUN_EN
         ovr_q   <= ovr_d;
`endif
      end
   end

   // Sequencing plus the capture datapath; abort pre-empts everything outside IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      sh_d    = sh_q;
      mode_d  = mode_q;
      if (abort) begin
         if (state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            k_d     = K_TOP;
         end
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               state_d = S_INIT;
               cnt_d   = '0;
               mode_d  = mode;
               k_d     = mode ? K_TOP : '0;
               sh_d    = '0;
            end
            S_INIT: if (cnt_q == INIT_LAST) begin
               state_d = S_COMP;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
            S_COMP: if (cnt_q == COMP_LAST) begin
               state_d   = S_UPD;
               cnt_d     = '0;
               sh_d[k_q] = comp;
            end else cnt_d = cnt_q + CW'(1);
            S_UPD: if (cnt_q == UPD_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
            S_GAP: if (k_q == '0) state_d = S_DONE;
                   else begin
                      k_d     = k_q - KW'(1);
                      state_d = S_COMP;
                   end
            S_DONE: begin
               state_d = S_IDLE;
               k_d     = K_TOP;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Strobes decode the next state so they come straight off flops, aligned with state_q.
   always_comb begin
      init_d = (state_d == S_INIT) && (cnt_d < INIT_LAST);
      cmp_d  = (state_d == S_COMP);
      upd_d  = (state_d == S_UPD);
      busy_d = (state_d inside {S_INIT, S_COMP, S_UPD, S_GAP});
      res_d  = res_q;
      vld_d  = vld_q;
`ifdef SAR_OVERRUN_EN
      ovr_d  = ovr_q;
`endif
      if (vld_q && result_ready) vld_d = 1'b0;
      if (state_q == S_DONE && !abort) begin
`ifdef SAR_OVERRUN_EN
         if (vld_q && !result_ready) ovr_d = 1'b1;
         else begin
            res_d = sh_q;
            vld_d = 1'b1;
         end
`else
         res_d = sh_q;
         vld_d = 1'b1;
`endif
      end
`ifdef SAR_OVERRUN_EN
      if (state_q == S_IDLE && start && !abort) ovr_d = 1'b0;
`endif
   end

   assign seq_init     = init_q;
   assign seq_update   = upd_q;
   assign seq_comp     = cmp_q;
   assign sar_mode     = mode_q;
   assign busy         = busy_q;
   assign result       = res_q;
   assign result_valid = vld_q;
`ifdef SAR_OVERRUN_EN
   assign overrun      = ovr_q;
`endif

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer (Nbits=4, COMP_DLY=2, PULSE_W=1); comp is fed from a pattern, MSB first.
module tb_sar_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, mode, comp, result_ready;
   logic       seq_init, seq_update, seq_comp, sar_mode, busy, result_valid;
   logic [3:0] result;
`ifdef SAR_OVERRUN_EN
   logic       overrun;
`endif

   logic [3:0] pat = 4'b0000;
   int         bit_i = 0;
   int         n_init = 0, n_upd = 0, n_ovl = 0;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   sar_sequencer #(.Nbits(4), .COMP_DLY(2), .PULSE_W(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .comp(comp),
      .result_ready(result_ready), .seq_init(seq_init), .seq_update(seq_update),
      .seq_comp(seq_comp), .sar_mode(sar_mode), .busy(busy), .result(result),
      .result_valid(result_valid)
`ifdef SAR_OVERRUN_EN
      , .overrun(overrun)
`endif
   );

   // Decision k of a conversion is pat[3-k]; the bit counter follows the update pulses.
   assign comp = (bit_i < 4) ? pat[3-bit_i] : 1'b0;

   always @(posedge clk) begin
      if (seq_init) bit_i <= 0;
      else if (seq_update) bit_i <= bit_i + 1;
      if (seq_init) n_init <= n_init + 1;
      if (seq_update) n_upd <= n_upd + 1;
      if (int'(seq_init) + int'(seq_update) + int'(seq_comp) > 1) n_ovl <= n_ovl + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic start_conv(input logic m, input logic [3:0] p);
      @(negedge clk);
      pat = p; mode = m; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
   endtask

   int lat, i0, u0;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; result_ready = 1'b0;
      #23;
      check("reset_outputs", {seq_init, seq_update, seq_comp, sar_mode, busy, result, result_valid}, 0);
      @(negedge clk) rst_n = 1'b1;
      result_ready = 1'b1;

      // Mode 1, decisions 1,0,1,1
      i0 = n_init; u0 = n_upd;
      start_conv(1'b1, 4'b1011);
      check("m1_busy_rise", busy, 1);
      wait_idle(lat);
      check("m1_busy_fall", lat, 18);
      check("m1_no_early_valid", result_valid, 0);
      @(posedge clk); #1;
      check("m1_valid_at_19", result_valid, 1);
      check("m1_result", result, 4'b1011);
      check("m1_sar_mode", sar_mode, 1);
      check("m1_init_pulses", n_init - i0, 1);
      check("m1_upd_pulses", n_upd - u0, 4);
      @(posedge clk); #1;
      check("m1_valid_consumed", result_valid, 0);

      // Mode 0, comp = 1
      u0 = n_upd;
      start_conv(1'b0, 4'b1000);
      wait_idle(lat);
      check("m0_busy_fall", lat, 6);
      @(posedge clk); #1;
      check("m0_valid_at_7", result_valid, 1);
      check("m0_result", result, 4'b0001);
      check("m0_sar_mode", sar_mode, 0);
      check("m0_upd_pulses", n_upd - u0, 1);

      // Back-pressure: result held while ready is low
      @(negedge clk) result_ready = 1'b0;
      start_conv(1'b1, 4'b0110);
      wait_idle(lat);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid", result_valid, 1);
         check("hold_result", result, 4'b0110);
      end
      @(negedge clk) result_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release", result_valid, 0);

      // Abort during the third comparison
      start_conv(1'b1, 4'b1111);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("abort_in_comp", seq_comp, 1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_strobes", {seq_init, seq_update, seq_comp}, 0);
      repeat (20) @(posedge clk); #1;
      check("abort_no_valid", result_valid, 0);
      check("abort_result_kept", result, 4'b0110);
      start_conv(1'b1, 4'b1001);
      wait_idle(lat);
      check("restart_busy_fall", lat, 18);
      @(posedge clk); #1;
      check("restart_valid", result_valid, 1);
      check("restart_result", result, 4'b1001);

      // Start and abort together in IDLE: abort wins
      @(negedge clk) begin start = 1'b1; abort = 1'b1; end
      @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
      check("start_abort_idle", {busy, seq_init}, 0);

      // Start pulses while busy are ignored
      i0 = n_init;
      start_conv(1'b1, 4'b0101);
      repeat (3) @(posedge clk);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_idle(lat);
      @(posedge clk); #1;
      check("busy_start_result", result, 4'b0101);
      repeat (3) @(posedge clk); #1;
      check("busy_start_one_init", n_init - i0, 1);

      // Async reset in the middle of the first update pulse
      start_conv(1'b1, 4'b1110);
      repeat (4) @(posedge clk); #1;
      check("rst_in_upd", seq_update, 1);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {seq_init, seq_update, seq_comp, sar_mode, busy, result, result_valid}, 0);
      @(negedge clk) rst_n = 1'b1;

      // Two results without consumption
      @(negedge clk) result_ready = 1'b0;
      start_conv(1'b1, 4'b1100);
      wait_idle(lat);
      @(posedge clk); #1;
      check("ovr_first_result", result, 4'b1100);
      start_conv(1'b1, 4'b0011);
      wait_idle(lat);
      @(posedge clk); #1;
      check("ovr_valid", result_valid, 1);
`ifdef SAR_OVERRUN_EN
      check("ovr_flag", overrun, 1);
      check("ovr_result_kept", result, 4'b1100);
`else
      check("latest_wins", result, 4'b0011);
`endif
      @(negedge clk) result_ready = 1'b1;
      start_conv(1'b1, 4'b1010);
`ifdef SAR_OVERRUN_EN
      check("ovr_cleared", overrun, 0);
`endif
      wait_idle(lat);
      @(posedge clk); #1;
      check("final_valid", result_valid, 1);
      check("final_result", result, 4'b1010);
      check("no_strobe_overlap", n_ovl, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
